// File: rtl/p18_video_pkg.sv
// rtl/p18_video_pkg.sv - default 640x480 timing, phase type and timing helper functions
package p18_video_pkg;

    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFRONT  = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBACK   = 48;
    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFRONT  = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBACK   = 33;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    function automatic int blank_of(input int front, input int sync, input int back);
        return front + sync + back;
    endfunction

    function automatic int total_of(input int active, input int front, input int sync,
                                    input int back);
        return active + blank_of(front, sync, back);
    endfunction

    // Blanking occupies the negative counts: front porch, then sync, then back porch up to -1.
    function automatic phase_e phase_of(input int c, input int front, input int sync,
                                        input int back);
        int blank;
        blank = blank_of(front, sync, back);
        if (c >= 0)
            return PH_ACTIVE;
        else if (c < -blank + front)
            return PH_FRONT;
        else if (c <= -back - 1)
            return PH_SYNC;
        else
            return PH_BACK;
    endfunction

endpackage

// File: rtl/p18_axis_counter.sv
// rtl/p18_axis_counter.sv - one raster axis: signed position counter with registered phase flags
module p18_axis_counter
    import p18_video_pkg::*;
#(
    parameter int ACTIVE = DEF_HACTIVE,
    parameter int FRONT  = DEF_HFRONT,
    parameter int SYNC   = DEF_HSYNC,
    parameter int BACK   = DEF_HBACK,
    parameter int W      = $clog2(total_of(ACTIVE, FRONT, SYNC, BACK)) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_i,
    output logic signed [W-1:0] count_o,
    output logic                at_end_o,
    output logic                sync_o,
    output logic                active_o
);

    localparam int BLANK = blank_of(FRONT, SYNC, BACK);
    localparam logic signed [W-1:0] FIRST = W'(-BLANK);
    localparam logic signed [W-1:0] LAST  = W'(ACTIVE - 1);

    logic signed [W-1:0] count_q, count_d;
    logic                sync_q, sync_d;
    logic                active_q, active_d;
    phase_e              phase_d;

    // Flags decode the next count so they line up with the count register they describe.
    always_comb begin
        count_d = count_q;
        if (step_i)
            count_d = (count_q == LAST) ? FIRST : count_q + W'(1);
        phase_d  = phase_of(int'(count_d), FRONT, SYNC, BACK);
        sync_d   = (phase_d == PH_SYNC);
        active_d = (phase_d == PH_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= FIRST;
            sync_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sync_q   <= sync_d;
            active_q <= active_d;
        end
    end

    assign count_o  = count_q;
    assign at_end_o = (count_q == LAST);
    assign sync_o   = sync_q;
    assign active_o = active_q;

endmodule

// File: rtl/p18_video_timing.sv
// rtl/p18_video_timing.sv - raster timing generator with sync, strobes and animation time
module p18_video_timing
    import p18_video_pkg::*;
#(
    parameter int HACTIVE  = DEF_HACTIVE,
    parameter int HFRONT   = DEF_HFRONT,
    parameter int HSYNC    = DEF_HSYNC,
    parameter int HBACK    = DEF_HBACK,
    parameter int VACTIVE  = DEF_VACTIVE,
    parameter int VFRONT   = DEF_VFRONT,
    parameter int VSYNC    = DEF_VSYNC,
    parameter int VBACK    = DEF_VBACK,
    parameter int SYNC_POL = 0,
    parameter int TIME_DIV = 1,
    parameter int HW       = $clog2(total_of(HACTIVE, HFRONT, HSYNC, HBACK)) + 1,
    parameter int VW       = $clog2(total_of(VACTIVE, VFRONT, VSYNC, VBACK)) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic                 time_run,
    input  logic                 time_clear,
    output logic signed [HW-1:0] counter_h,
    output logic signed [VW-1:0] counter_v,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [7:0]           cur_time
);

    localparam logic       SYNC_ACT = (SYNC_POL != 0);
    localparam logic [3:0] DIV_LAST = 4'(TIME_DIV - 1);

    logic h_end, h_sync, h_act;
    logic v_end, v_sync, v_act;
    logic v_step, frame_wrap;

    assign v_step     = pix_en & h_end;
    assign frame_wrap = v_step & v_end;

    p18_axis_counter #(
        .ACTIVE (HACTIVE),
        .FRONT  (HFRONT),
        .SYNC   (HSYNC),
        .BACK   (HBACK),
        .W      (HW)
    ) u_h (
        .clk      (clk),
        .reset    (reset),
        .step_i   (pix_en),
        .count_o  (counter_h),
        .at_end_o (h_end),
        .sync_o   (h_sync),
        .active_o (h_act)
    );

    p18_axis_counter #(
        .ACTIVE (VACTIVE),
        .FRONT  (VFRONT),
        .SYNC   (VSYNC),
        .BACK   (VBACK),
        .W      (VW)
    ) u_v (
        .clk      (clk),
        .reset    (reset),
        .step_i   (v_step),
        .count_o  (counter_v),
        .at_end_o (v_end),
        .sync_o   (v_sync),
        .active_o (v_act)
    );

    logic       line_q, frame_q;
    logic [3:0] div_q, div_d;
    logic [7:0] time_q, time_d;

    // Clear wins over a same-cycle increment and is honoured even with pix_en low.
    always_comb begin
        div_d  = div_q;
        time_d = time_q;
        if (time_clear) begin
            div_d  = 4'd0;
            time_d = 8'd0;
        end else if (frame_wrap && time_run) begin
            if (div_q == DIV_LAST) begin
                div_d  = 4'd0;
                time_d = time_q + 8'd1;
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            div_q   <= 4'd0;
            time_q  <= 8'd0;
        end else begin
            line_q  <= v_step;
            frame_q <= frame_wrap;
            div_q   <= div_d;
            time_q  <= time_d;
        end
    end

    assign hsync       = h_sync ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = v_sync ? SYNC_ACT : ~SYNC_ACT;
    assign de          = h_act & v_act;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign cur_time    = time_q;

endmodule
